// File: rtl/ro_sel_mux.sv
// ro_sel_mux: N-to-1 ring-oscillator selector with registered select and blanking window.
// Optional clk-domain synchroniser on the gated output is enabled by defining RO_SEL_SYNC_EN.
module ro_sel_mux #(
    parameter int N_IN          = 16,
    parameter int SEL_W         = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  ro_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic             ro_dis,
    output logic             sel_err,
    output logic [SEL_W-1:0] cur_sel,
    output logic             ro_live,
    output logic             ro_out,
    output logic             ro_sync
);

    typedef enum logic [1:0] {IDLE, BLANK, LIVE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             gate;
    logic             ro_mux;
    logic             in_range;
    logic             req;
    logic             accept;
    logic             reject;

    assign in_range = 32'(sel_in) < N_IN;
    assign req      = sel_valid & sel_ready & ~ro_dis;
    assign accept   = req & in_range;
    assign reject   = req & ~in_range;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: release beats a new request; settle ends when the count reaches 1
    always_comb begin
        state_nxt = ro_dis ? IDLE :
                    accept ? BLANK :
                    (state == BLANK && cnt == CNT_W'(1)) ? LIVE : state;
    end

    // state-derived outputs
    always_comb begin
        sel_ready = state != BLANK;
        ro_live   = state == LIVE;
    end

    // select, settle counter, gate and error pulse; gate opens together with LIVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel <= '0;
            cnt     <= '0;
            gate    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            cur_sel <= accept ? sel_in : cur_sel;
            cnt     <= ro_dis ? '0 : accept ? CNT_W'(SETTLE_CYCLES) :
                       (state == BLANK) ? cnt - CNT_W'(1) : cnt;
            gate    <= state_nxt == LIVE;
            sel_err <= reject;
        end
    end

    // mux decode limited to real channels; unused select codes give 0
    always_comb begin
        ro_mux = 1'b0;
        for (int i = 0; i < N_IN; i++)
            if (cur_sel == SEL_W'(i)) ro_mux = ro_in[i];
    end

    assign ro_out = ro_mux & gate;

`ifdef RO_SEL_SYNC_EN
    logic [1:0] sync_q;

    // two-flop synchroniser bringing the gated RO into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], ro_out};
    end

    assign ro_sync = sync_q[1];
`else
    assign ro_sync = 1'b0;
`endif

endmodule

// File: tb/tb_ro_sel_mux.sv
// tb_ro_sel_mux: directed self-checking bench for ro_sel_mux (N_IN=12).
module tb_ro_sel_mux;

    localparam int N_IN  = 12;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_IN-1:0]  ro_in;
    logic [SEL_W-1:0] sel_in;
    logic             sel_valid;
    logic             sel_ready;
    logic             ro_dis;
    logic             sel_err;
    logic [SEL_W-1:0] cur_sel;
    logic             ro_live;
    logic             ro_out;
    logic             ro_sync;

    int errors = 0;
    int checks = 0;

    ro_sel_mux #(.N_IN(N_IN), .SEL_W(SEL_W), .SETTLE_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .sel_in(sel_in), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .ro_dis(ro_dis), .sel_err(sel_err), .cur_sel(cur_sel),
        .ro_live(ro_live), .ro_out(ro_out), .ro_sync(ro_sync)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [SEL_W-1:0] s);
        sel_in = s;
        sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; ro_in = '1; sel_in = '0; sel_valid = 1'b0; ro_dis = 1'b0;
        repeat (2) step();
        checks++; if (ro_live !== 1'b0) begin errors++; $display("FAIL reset_live got=%b exp=0", ro_live); end
        checks++; if (ro_out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", ro_out); end
        checks++; if (cur_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", cur_sel); end
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", sel_ready); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", sel_err); end
        checks++; if (ro_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got=%b exp=0", ro_sync); end
        rst = 1'b0;
        step();
        checks++; if (ro_live !== 1'b0) begin errors++; $display("FAIL idle_live got=%b exp=0", ro_live); end
    endtask

    task automatic test_select();
        sel_in = 4'd5; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        checks++; if (cur_sel !== 4'd5) begin errors++; $display("FAIL sel_cur got=%0d exp=5", cur_sel); end
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL sel_ready_blank got=%b exp=0", sel_ready); end
        for (int k = 1; k <= 7; k++) begin
            checks++; if (ro_live !== 1'b0 || ro_out !== 1'b0) begin errors++; $display("FAIL sel_blank edge=%0d live=%b out=%b exp=0,0", k - 1, ro_live, ro_out); end
            step();
        end
        checks++; if (ro_live !== 1'b0 || ro_out !== 1'b0) begin errors++; $display("FAIL sel_blank edge=7 live=%b out=%b exp=0,0", ro_live, ro_out); end
        step();
        checks++; if (ro_live !== 1'b1) begin errors++; $display("FAIL sel_live edge8 got=%b exp=1", ro_live); end
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL sel_ready_live got=%b exp=1", sel_ready); end
        checks++; if (ro_out !== 1'b1) begin errors++; $display("FAIL sel_out_hi got=%b exp=1", ro_out); end
        ro_in[5] = 1'b0; #1;
        checks++; if (ro_out !== 1'b0) begin errors++; $display("FAIL sel_out_lo got=%b exp=0", ro_out); end
        ro_in[5] = 1'b1; ro_in[4] = 1'b0; ro_in[6] = 1'b0; #1;
        checks++; if (ro_out !== 1'b1) begin errors++; $display("FAIL sel_out_other got=%b exp=1", ro_out); end
        ro_in = '1;
    endtask

    task automatic test_blank_ignore();
        sel_in = 4'd2; sel_valid = 1'b1;
        step();
        sel_in = 4'd7;
        checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL ign_ready got=%b exp=0", sel_ready); end
        step();
        sel_valid = 1'b0;
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL ign_err got=%b exp=0", sel_err); end
        checks++; if (cur_sel !== 4'd2) begin errors++; $display("FAIL ign_cur got=%0d exp=2", cur_sel); end
        repeat (6) step();
        checks++; if (ro_live !== 1'b0) begin errors++; $display("FAIL ign_live_e7 got=%b exp=0", ro_live); end
        step();
        checks++; if (ro_live !== 1'b1 || cur_sel !== 4'd2) begin errors++; $display("FAIL ign_live_e8 live=%b sel=%0d exp=1,2", ro_live, cur_sel); end
    endtask

    task automatic test_reject();
        logic [SEL_W-1:0] bad [2] = '{4'd13, 4'd12};
        for (int i = 0; i < 2; i++) begin
            sel_in = bad[i]; sel_valid = 1'b1;
            step();
            sel_valid = 1'b0;
            checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL rej_err sel=%0d got=%b exp=1", bad[i], sel_err); end
            checks++; if (cur_sel !== 4'd2 || ro_live !== 1'b1) begin errors++; $display("FAIL rej_hold sel=%0d cur=%0d live=%b exp=2,1", bad[i], cur_sel, ro_live); end
            step();
            checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rej_pulse sel=%0d got=%b exp=0", bad[i], sel_err); end
        end
    endtask

    task automatic test_dis();
        ro_dis = 1'b1; sel_in = 4'd3; sel_valid = 1'b1;
        step();
        ro_dis = 1'b0; sel_valid = 1'b0;
        checks++; if (ro_live !== 1'b0 || ro_out !== 1'b0) begin errors++; $display("FAIL dis_live live=%b out=%b exp=0,0", ro_live, ro_out); end
        checks++; if (cur_sel !== 4'd2) begin errors++; $display("FAIL dis_cur got=%0d exp=2", cur_sel); end
        checks++; if (sel_ready !== 1'b1 || sel_err !== 1'b0) begin errors++; $display("FAIL dis_ready ready=%b err=%b exp=1,0", sel_ready, sel_err); end
    endtask

    task automatic test_dis_blank();
        sel_in = 4'd11; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        checks++; if (cur_sel !== 4'd11) begin errors++; $display("FAIL dbl_cur got=%0d exp=11", cur_sel); end
        repeat (4) step();
        ro_dis = 1'b1;
        step();
        ro_dis = 1'b0;
        checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL dbl_idle got=%b exp=1", sel_ready); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (ro_live !== 1'b0 || ro_out !== 1'b0) begin errors++; $display("FAIL dbl_nolive k=%0d live=%b out=%b exp=0,0", k, ro_live, ro_out); end
            step();
        end
        checks++; if (cur_sel !== 4'd11) begin errors++; $display("FAIL dbl_hold got=%0d exp=11", cur_sel); end
    endtask

    task automatic test_sync();
        logic hist [40];
        logic exp;
        select(4'd5);
        checks++; if (ro_live !== 1'b1) begin errors++; $display("FAIL sync_live got=%b exp=1", ro_live); end
        for (int i = 0; i < 40; i++) begin
            ro_in[5] = ((i / 5) % 2) == 0; #1;
            hist[i] = ro_out;
`ifdef RO_SEL_SYNC_EN
            exp = (i >= 2) ? hist[i - 2] : 1'b1;
`else
            exp = 1'b0;
`endif
            if (i >= 2) begin
                checks++; if (ro_sync !== exp) begin errors++; $display("FAIL sync i=%0d got=%b exp=%b", i, ro_sync, exp); end
            end
            step();
        end
        ro_in = '1;
    endtask

    task automatic test_async_reset();
        checks++; if (ro_live !== 1'b1) begin errors++; $display("FAIL ar_pre got=%b exp=1", ro_live); end
        #3 rst = 1'b1;
        #1;
        checks++; if (ro_live !== 1'b0 || ro_out !== 1'b0) begin errors++; $display("FAIL ar_live live=%b out=%b exp=0,0", ro_live, ro_out); end
        checks++; if (cur_sel !== 4'd0 || sel_ready !== 1'b1) begin errors++; $display("FAIL ar_sel cur=%0d ready=%b exp=0,1", cur_sel, sel_ready); end
        step();
        rst = 1'b0;
        step();
        checks++; if (ro_live !== 1'b0 || ro_sync !== 1'b0) begin errors++; $display("FAIL ar_after live=%b sync=%b exp=0,0", ro_live, ro_sync); end
    endtask

    initial begin
        test_reset();
        test_select();
        test_blank_ignore();
        test_reject();
        test_dis();
        test_dis_blank();
        test_sync();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
